uart_tx_sched: RTL
==================

# uart_tx_sched

Packet scheduler that shares one UART transmit core among `N_REQ` byte-stream requesters. It arbitrates round-robin and holds the grant for a whole packet. Each packet goes out as a header byte (channel ID), the payload bytes, then an XOR checksum. It drives the transmit FSM's start/data inputs and paces every byte on that core's `busy` output.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, legal range 2..8
- `MAX_LEN`, 16: maximum payload bytes per packet, legal range 1..255
- `HDR_BASE`, 8'hA0: header byte is `HDR_BASE | id`; low 3 bits of `HDR_BASE` must be 0

Ports:
- `clk_50M` in 1: system clock; all logic on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in N_REQ: requester i has a payload byte on its lane
- `req_data` in 8*N_REQ: lane i is bits [8i+7:8i]
- `req_last` in N_REQ: the byte on lane i is the final payload byte
- `req_ready` out N_REQ: one-hot; the byte on lane i is accepted when ready[i] & valid[i]
- `tx_en` out 1: one-cycle start pulse to the transmit core
- `tx_data` out 8: byte to transmit; valid while `tx_en` is high and held until the next `tx_en`
- `tx_busy` in 1: transmit core busy
- `grant` out N_REQ: one-hot; the current packet owner; 0 when idle
- `pkt_done` out 1: one-cycle pulse after the checksum byte completes
- `trunc` out 1: one-cycle pulse together with `pkt_done` when the packet was cut at `MAX_LEN`

## Operation
- States: IDLE, HDR, FETCH, ISSUE, WAIT_HI, WAIT_LO, CSUM, DONE. The register `phase` ∈ {HDR, PAY, CSUM} records which byte is in flight.
- **IDLE:** when any `req_valid` is high and `tx_busy` = 0, pick the winner by round-robin, register `grant`, then go to HDR.
  - Search order starts at `ptr`. After each packet, `ptr` = owner + 1 mod N_REQ. Reset sets `ptr` = 0.
  - If `tx_busy` = 1, stay in IDLE.
- **HDR:** `tx_data` = `HDR_BASE | id`, `tx_en` = 1, `csum` = header, `cnt` = 0, then go to WAIT_HI.
- **FETCH:** `req_ready[id]` = 1 (combinational from state and grant).
  - On valid: latch the byte and `last`, `csum ^= byte`, `cnt++`, then go to ISSUE.
  - With no valid: wait indefinitely with no timeout. The grant is held.
- **ISSUE:** `tx_data` = latched byte, `tx_en` = 1, then go to WAIT_HI.
- **WAIT_HI:** wait for `tx_busy` = 1, then go to WAIT_LO.
- **WAIT_LO:** wait for `tx_busy` = 0, then branch on `phase`:
  - after HDR: go to FETCH
  - after PAY: go to CSUM if latched last = 1 or `cnt` = MAX_LEN, otherwise go to FETCH
  - after CSUM: go to DONE
- **CSUM:** `tx_data` = `csum`, `tx_en` = 1, then go to WAIT_HI.
- **DONE:** `pkt_done` = 1, `trunc` = (`cnt` = MAX_LEN and last = 0), `grant` = 0, update `ptr`, then go to IDLE.
- **Truncation:** when `MAX_LEN` is reached without `req_last`, the requester's next byte becomes the first payload byte of its next packet (it receives a new header).
- **Arithmetic:** `csum` is 8-bit XOR of the header and all payload bytes; `cnt` is 8 bits and never exceeds `MAX_LEN`.
- `req_valid` from non-granted lanes is ignored mid-packet; their `req_ready` stays 0.

## Timing
- **Reset values** (immediate, asynchronous): `req_ready` = 0, `tx_en` = 0, `tx_data` = 0, `grant` = 0, `pkt_done` = 0, `trunc` = 0, `ptr` = 0, `csum` = 0, `cnt` = 0, state = IDLE.
- Reset mid-packet aborts with no checksum and no `pkt_done`. The transmit core is reset by the same `rst_n`.
- **Start latency:** `req_valid` sampled in IDLE at cycle 0 → `grant` at cycle 1 and `tx_en` with header at cycle 1.
- **Payload handshake:** handshake at cycle f → `tx_en` at f+1.
- **Byte pacing:** `tx_busy` sampled low in WAIT_LO at cycle w → next `tx_en` (header → first payload) no earlier than w+2, because FETCH occupies w+1.
- **Checksum:** `tx_en` for the checksum at w+1; `pkt_done` at w_csum+1.
- **Transmit-core contract:** the core raises `tx_busy` within cycles 1..2 after `tx_en`. `tx_en` is never reasserted while in WAIT_HI or WAIT_LO. `tx_en` is never high two consecutive cycles.
- **Back-to-back packets:** a new arbitration occurs in IDLE the cycle after DONE. Minimum gap from `pkt_done` to the next header `tx_en` is 2 cycles.

## Test plan
- **Single packet, lane 2:** lane 2 sends 8'h11, then 8'h22 with last, transmit model busy 10 cycles per byte → `tx_data` sequence A2, 11, 22, 91; one `pkt_done`; `trunc` = 0; `grant` = 4'b0100 throughout.
- **Round-robin:** lanes 0, 1 and 3 all valid with 1-byte packets continuously → headers A0, A1, A3, A0; no lane is granted twice while another is pending.
- **Truncation:** `MAX_LEN` = 16, lane 1 streams 20 bytes with last on byte 20 →
  - first packet: A1 + 16 bytes + checksum, then `trunc` = 1
  - second packet: A1 + 4 bytes + checksum, then `trunc` = 0
- **Valid gap:** lane 0 deasserts valid for 30 cycles mid-packet → FETCH holds, `req_ready[0]` stays high, `grant` held, no `tx_en` during the gap, checksum correct.
- **Busy held:** `tx_busy` forced high while IDLE with lane 0 valid → no grant until `tx_busy` falls; `tx_en` never asserted during WAIT states.
- **Reset mid-payload:** `rst_n` low during WAIT_LO of the 2nd payload byte → all outputs 0 in the same cycle; after release, lane 0 (`ptr` = 0) is granted first.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Packet scheduler in front of a single UART transmit core.
// Requesters are served round-robin; each packet is sent as a header byte
// (HDR_BASE | id), the payload bytes, then an XOR checksum of all of them.
// Every byte is paced on the transmit core's busy output.
module uart_tx_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               pkt_done,
  output logic               trunc
);

  localparam int unsigned IdW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHdr    = 3'd1;
  localparam logic [2:0] StFetch  = 3'd2;
  localparam logic [2:0] StIssue  = 3'd3;
  localparam logic [2:0] StWaitHi = 3'd4;
  localparam logic [2:0] StWaitLo = 3'd5;
  localparam logic [2:0] StCsum   = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  localparam logic [1:0] PhHdr  = 2'd0;
  localparam logic [1:0] PhPay  = 2'd1;
  localparam logic [1:0] PhCsum = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             win_found;
  logic [IdW-1:0]   win_id;
  logic [IdW-1:0]   ptr_nxt;
  logic [7:0]       sel_data;
  logic             sel_valid;
  logic             sel_last;

  // Round-robin search starting at ptr_q; first valid lane wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(N_REQ);
      if (!win_found && req_valid[IdW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IdW'(idx);
      end
    end
  end

  // Granted lane's byte, last flag and valid, plus the post-packet pointer.
  always_comb begin
    sel_data  = req_data[{id_q, 3'b000} +: 8];
    sel_valid = req_valid[id_q];
    sel_last  = req_last[id_q];
    ptr_nxt   = (id_q == IdW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
  end

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    phase_d   = phase_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (win_found && !tx_busy) begin
          grant_d   = N_REQ'(1) << win_id;
          id_d      = win_id;
          // Loaded one edge early so the header is on tx_data with tx_en.
          tx_data_d = HDR_BASE | {{(8 - IdW){1'b0}}, win_id};
          state_d   = StHdr;
        end
      end
      StHdr: begin
        csum_d  = tx_data_q;
        cnt_d   = '0;
        last_d  = 1'b0;
        phase_d = PhHdr;
        state_d = StWaitHi;
      end
      StFetch: begin
        if (sel_valid) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          csum_d    = csum_q ^ sel_data;
          cnt_d     = cnt_q + 8'd1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        phase_d = PhPay;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (tx_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (phase_q == PhHdr) begin
            state_d = StFetch;
          end else if (phase_q == PhPay) begin
            if (last_q || (cnt_q == MaxLenB)) begin
              tx_data_d = csum_q;
              state_d   = StCsum;
            end else begin
              state_d = StFetch;
            end
          end else begin
            state_d = StDone;
          end
        end
      end
      StCsum: begin
        phase_d = PhCsum;
        state_d = StWaitHi;
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = ptr_nxt;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any packet in flight.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      phase_q   <= PhHdr;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      phase_q   <= phase_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    tx_en     = (state_q == StHdr) || (state_q == StIssue) || (state_q == StCsum);
    tx_data   = tx_data_q;
    req_ready = (state_q == StFetch) ? grant_q : '0;
    grant     = grant_q;
    pkt_done  = (state_q == StDone);
    trunc     = (state_q == StDone) && (cnt_q == MaxLenB) && !last_q;
  end

endmodule
